count_sweep_ctrl: RTL

Sweep controller for the 4-bit up/down counter datapath. It accepts a start request with a low bound, a high bound and a pass count. It then steers the counter by driving its direction (Count_up) and an advance enable: first it seeks the counter to the low bound, then it ping-pongs between the bounds for the requested number of half-sweeps, and finally signals completion. It sits between the control/test logic and the counter, closing the loop through the counter's Count output.

---
 rtl/count_sweep_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/count_sweep_ctrl.sv
// Purpose : sweep controller that seeks a 4-bit up/down counter to a low bound,
//           then ping-pongs it between the low and high bounds for a set number of half-sweeps.
// Latency : Busy rises 1 cycle after Start is accepted. Done arrives
//           1 + (|C0-Lo|+1) + Passes*((Hi-Lo)+1) cycles after the cycle in which Start is high.
// Backpr. : none. Start is taken only in IDLE and is never queued. Abort cancels at once in any state.
//
// Ports:
//   Clk, Reset          clock (rising edge) and asynchronous active-high reset
//   Start, Lo, Hi,      sweep request and its parameters, captured on acceptance
//   Passes
//   Abort               synchronous cancel; also gates Count_en in the same cycle
//   Count               counter value fed back from the controlled counter
//   Count_up, Count_en  counter direction (1 = +1) and advance enable (combinational)
//   Busy                high while seeking or sweeping
//   Done, Err           one-cycle registered pulses: completion / rejected Start (Lo > Hi)
`timescale 1ns/1ps
module count_sweep_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Lo,
  input  logic [3:0] Hi,
  input  logic [3:0] Passes,
  input  logic       Abort,
  input  logic [3:0] Count,
  output logic       Count_up,
  output logic       Count_en,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEEK = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state, state_nx;
  logic [3:0] lo_r, lo_nx;
  logic [3:0] hi_r, hi_nx;
  logic [3:0] rem, rem_nx;
  logic       err_q, err_nx;
  logic       cu, ce;

  always_comb begin
    state_nx = state;
    lo_nx    = lo_r;
    hi_nx    = hi_r;
    rem_nx   = rem;
    err_nx   = 1'b0;
    cu       = 1'b0;
    ce       = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          if (Lo > Hi) begin
            err_nx = 1'b1;
          end else begin
            lo_nx    = Lo;
            hi_nx    = Hi;
            rem_nx   = (Passes == 4'd0) ? 4'd1 : Passes;
            state_nx = S_SEEK;
          end
        end
      end

      // Direction is chosen by magnitude, so the seek never wraps through 15/0.
      S_SEEK: begin
        cu = (Count < lo_r);
        ce = (Count != lo_r);
        if (Count == lo_r) state_nx = S_UP;
      end

      // Reaching the bound costs one dwell cycle with ce=0. That cycle is
      // where the pass count is consumed and the direction turns around.
      S_UP: begin
        cu = 1'b1;
        ce = (Count != hi_r);
        if (Count == hi_r) begin
          if (rem == 4'd1) begin
            state_nx = S_DONE;
          end else begin
            rem_nx   = rem - 4'd1;
            state_nx = S_DOWN;
          end
        end
      end

      S_DOWN: begin
        cu = 1'b0;
        ce = (Count != lo_r);
        if (Count == lo_r) begin
          if (rem == 4'd1) begin
            state_nx = S_DONE;
          end else begin
            rem_nx   = rem - 4'd1;
            state_nx = S_UP;
          end
        end
      end

      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Abort wins over everything, including a Start in the same IDLE cycle.
    if (Abort) begin
      state_nx = S_IDLE;
      rem_nx   = 4'd0;
      lo_nx    = lo_r;
      hi_nx    = hi_r;
      err_nx   = 1'b0;
      ce       = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      lo_r  <= 4'd0;
      hi_r  <= 4'd0;
      rem   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      lo_r  <= lo_nx;
      hi_r  <= hi_nx;
      rem   <= rem_nx;
      err_q <= err_nx;
    end
  end

  // Reset forces state to IDLE asynchronously, so ce drops (and the counter
  // freezes) in the same cycle that Reset asserts.
  assign Count_up = cu;
  assign Count_en = ce;
  assign Busy     = (state == S_SEEK) || (state == S_UP) || (state == S_DOWN);
  assign Done     = (state == S_DONE);
  assign Err      = err_q;

endmodule
